// File: rtl/dsc_mul_nway.sv
// dsc_mul_nway - deterministic stochastic-computing N-input multiplier.
//
// Each operand has its own unary stream generator (dsc_sng_lane). The lane
// counters form one enable chain on a single clock. Over 2^(N*W) RUN cycles
// the chain visits every combination of counter values exactly once. The
// combined bit is counted once per cycle, so the count is exact:
//   mode=0 (AND): z = prod(x_i)
//   mode=1 (OR) : z = 2^(N*W) - prod(2^W - x_i)
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  begin a run (sampled in IDLE only)
//   abort  cancel the current run (ignored in IDLE)
//   mode   0 = AND, 1 = OR; latched at start
//   x_in   flattened operands, operand i = x_in[i*W +: W]; latched at start
//   busy   high while a run is in progress
//   done   one-cycle pulse when z has been updated
//   z      result of the last completed run

// One SNG lane: a wrapping counter and its unary comparator.
//   clk, rst : clock and async active-high reset
//   clr      : synchronous clear of the counter (run start)
//   en       : count enable from the chain
//   x        : latched operand for this lane
//   s        : stream bit, cnt < x
//   wrap     : counter is all ones, so it wraps on its next enabled edge
module dsc_sng_lane #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] x,
    output logic         s,
    output logic         wrap
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    end

    assign s    = (cnt < x);
    assign wrap = &cnt;
endmodule

module dsc_mul_nway #(
    parameter int SNG_WIDTH  = 6,
    parameter int NUM_INPUTS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             mode,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  x_in,
    output logic                             busy,
    output logic                             done,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0]  z
);
    localparam int W  = SNG_WIDTH;
    localparam int N  = NUM_INPUTS;
    localparam int ZW = N * W;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic                mode;
        logic [N-1:0][W-1:0] x;
    } cfg_t;

    state_t        state, state_nx;
    cfg_t          cfg;
    logic [ZW-1:0] acc;
    logic [N-1:0]  s, wrap;
    logic [N:0]    en;
    logic          ld, fin, term, bit_b;

    // Enable chain: lane i counts only when all lower lanes are about to wrap.
    // The enable that falls off the top of the chain marks the terminal edge.
    assign en[0] = (state == RUN);
    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_chain
            assign en[g+1] = en[g] & wrap[g];
        end
    endgenerate
    assign term = en[N];

    dsc_sng_lane #(.W(W)) u_lane [N-1:0] (
        .clk  (clk),
        .rst  (rst),
        .clr  (ld),
        .en   (en[N-1:0]),
        .x    (cfg.x),
        .s    (s),
        .wrap (wrap)
    );

    assign bit_b = cfg.mode ? |s : &s;
    assign busy  = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ld       = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // abort beats the terminal edge: no done, z untouched
                if (abort) begin
                    state_nx = IDLE;
                end else if (term) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg  <= '0;
            acc  <= '0;
            z    <= '0;
            done <= 1'b0;
        end else begin
            done <= fin;
            if (ld) begin
                cfg.mode <= mode;
                cfg.x    <= x_in;
                acc      <= '0;
            end else if (state == RUN) begin
                acc <= acc + {{(ZW-1){1'b0}}, bit_b};
            end
            // the terminal cycle's bit is folded in directly
            if (fin) z <= acc + {{(ZW-1){1'b0}}, bit_b};
        end
    end
endmodule

// File: tb/tb_dsc_mul_nway.sv
module tb_dsc_mul_nway;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: W=2, N=2 (16-cycle runs)
    logic       start_a = 0, abort_a = 0, mode_a = 0;
    logic [3:0] x_a = 0;
    logic       busy_a, done_a;
    logic [3:0] z_a;
    // DUT B: W=3, N=3 (512-cycle runs)
    logic       start_b = 0, abort_b = 0, mode_b = 0;
    logic [8:0] x_b = 0;
    logic       busy_b, done_b;
    logic [8:0] z_b;

    int checks = 0;
    int errors = 0;

    dsc_mul_nway #(.SNG_WIDTH(2), .NUM_INPUTS(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mode(mode_a),
        .x_in(x_a), .busy(busy_a), .done(done_a), .z(z_a)
    );
    dsc_mul_nway #(.SNG_WIDTH(3), .NUM_INPUTS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mode(mode_b),
        .x_in(x_b), .busy(busy_b), .done(done_b), .z(z_b)
    );

    // Closed-form result of a run.
    function automatic int ref_z(input int w, input int n, input int xs[3], input bit m);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * (m ? ((1 << w) - xs[i]) : xs[i]);
        return m ? ((1 << (n * w)) - p) : p;
    endfunction

    // Issue a start to DUT A; returns at the negedge after the start edge.
    task automatic go_a(input int x0, input int x1, input bit m);
        @(negedge clk);
        x_a = {2'(x1), 2'(x0)};
        mode_a = m;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
    endtask

    // Count busy cycles until done; returns on the done cycle's negedge.
    task automatic wait_a(output int cyc, output bit got);
        cyc = 0;
        got = 0;
        for (int k = 0; k < 100; k++) begin
            if (done_a) begin
                got = 1;
                break;
            end
            if (busy_a) cyc++;
            @(negedge clk);
        end
    endtask

    task automatic go_b(input int x0, input int x1, input int x2, input bit m);
        @(negedge clk);
        x_b = {3'(x2), 3'(x1), 3'(x0)};
        mode_b = m;
        start_b = 1;
        @(negedge clk);
        start_b = 0;
    endtask

    task automatic wait_b(output int cyc, output bit got);
        cyc = 0;
        got = 0;
        for (int k = 0; k < 2000; k++) begin
            if (done_b) begin
                got = 1;
                break;
            end
            if (busy_b) cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy_a, done_a, z_a} !== 6'd0) begin
            errors++;
            $display("FAIL reset_a: busy=%b done=%b z=%0d expected all 0", busy_a, done_a, z_a);
        end
        checks++;
        if ({busy_b, done_b, z_b} !== 11'd0) begin
            errors++;
            $display("FAIL reset_b: busy=%b done=%b z=%0d expected all 0", busy_b, done_b, z_b);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_product();
        int cyc, e;
        bit got;
        int xs[3];
        go_a(3, 2, 0);
        wait_a(cyc, got);
        checks++;
        if (!got || cyc != 16) begin
            errors++;
            $display("FAIL prod_latency: got=%0d busy_cycles=%0d expected done after 16", got, cyc);
        end
        checks++;
        if (z_a !== 4'd6) begin
            errors++;
            $display("FAIL prod_3x2: z=%0d expected 6", z_a);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || z_a !== 4'd6) begin
            errors++;
            $display("FAIL done_pulse: done=%b z=%0d expected 0 and 6", done_a, z_a);
        end
        for (int t = 0; t < 12; t++) begin
            xs[0] = $urandom_range(0, 3);
            xs[1] = $urandom_range(0, 3);
            xs[2] = 0;
            e = ref_z(2, 2, xs, t[0]);
            go_a(xs[0], xs[1], t[0]);
            wait_a(cyc, got);
            checks++;
            if (!got || cyc != 16 || z_a !== 4'(e)) begin
                errors++;
                $display("FAIL rand_a: x=(%0d,%0d) mode=%0d got=%0d cycles=%0d z=%0d expected z=%0d cycles=16",
                         xs[0], xs[1], t[0], got, cyc, z_a, e);
            end
        end
    endtask

    task automatic test_or();
        int cyc;
        bit got;
        go_a(1, 1, 1);
        wait_a(cyc, got);
        checks++;
        if (!got || z_a !== 4'd7) begin
            errors++;
            $display("FAIL or_1_1: got=%0d z=%0d expected 7", got, z_a);
        end
        go_a(0, 0, 1);
        wait_a(cyc, got);
        checks++;
        if (!got || z_a !== 4'd0) begin
            errors++;
            $display("FAIL or_0_0: got=%0d z=%0d expected 0", got, z_a);
        end
    endtask

    task automatic test_wide();
        int cyc, e;
        bit got;
        int xs[3];
        go_b(7, 7, 7, 0);
        wait_b(cyc, got);
        checks++;
        if (!got || cyc != 512 || z_b !== 9'd343) begin
            errors++;
            $display("FAIL wide_777: got=%0d cycles=%0d z=%0d expected 512 cycles z=343", got, cyc, z_b);
        end
        go_b(5, 0, 7, 0);
        wait_b(cyc, got);
        checks++;
        if (!got || z_b !== 9'd0) begin
            errors++;
            $display("FAIL wide_zero: got=%0d z=%0d expected 0", got, z_b);
        end
        for (int t = 0; t < 3; t++) begin
            foreach (xs[i]) xs[i] = $urandom_range(0, 7);
            e = ref_z(3, 3, xs, t[0]);
            go_b(xs[0], xs[1], xs[2], t[0]);
            wait_b(cyc, got);
            checks++;
            if (!got || z_b !== 9'(e)) begin
                errors++;
                $display("FAIL rand_b: x=(%0d,%0d,%0d) mode=%0d got=%0d z=%0d expected %0d",
                         xs[0], xs[1], xs[2], t[0], got, z_b, e);
            end
        end
    endtask

    task automatic test_handshake();
        int cyc, dn, last;
        bit got;
        // start held through the whole run, operands disturbed mid-run
        @(negedge clk);
        x_a = {2'd3, 2'd2};
        mode_a = 0;
        start_a = 1;
        dn = 0;
        last = -1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (k == 4) begin
                x_a = 4'($urandom_range(0, 15));
                mode_a = 1;
            end
            if (done_a) begin
                dn++;
                last = k;
            end
        end
        start_a = 0;
        checks++;
        if (dn != 1 || last != 16 || z_a !== 4'd6) begin
            errors++;
            $display("FAIL held_start: dones=%0d at=%0d z=%0d expected 1 done at 16 z=6", dn, last, z_a);
        end
        // back-to-back: restart in the done cycle
        go_a(1, 2, 0);
        wait_a(cyc, got);
        x_a = {2'd3, 2'd3};
        mode_a = 1;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        checks++;
        if (busy_a !== 1'b1 || z_a !== 4'd2) begin
            errors++;
            $display("FAIL back_to_back: busy=%b z=%0d expected busy=1 z=2", busy_a, z_a);
        end
        wait_a(cyc, got);
        checks++;
        if (!got || cyc != 16 || z_a !== 4'd15) begin
            errors++;
            $display("FAIL b2b_second: got=%0d cycles=%0d z=%0d expected 16 cycles z=15", got, cyc, z_a);
        end
    endtask

    task automatic test_abort();
        int cyc, dn;
        bit got;
        go_a(3, 3, 0);
        wait_a(cyc, got);
        checks++;
        if (!got || z_a !== 4'd9) begin
            errors++;
            $display("FAIL abort_pre: z=%0d expected 9", z_a);
        end
        go_a(2, 2, 0);
        repeat (6) @(negedge clk);
        abort_a = 1;
        @(negedge clk);
        abort_a = 0;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || z_a !== 4'd9) begin
            errors++;
            $display("FAIL abort_edge7: busy=%b done=%b z=%0d expected 0 0 9", busy_a, done_a, z_a);
        end
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a) dn++;
        end
        checks++;
        if (dn != 0 || z_a !== 4'd9) begin
            errors++;
            $display("FAIL abort_nodone: dones=%0d z=%0d expected 0 and 9", dn, z_a);
        end
        go_a(2, 3, 0);
        wait_a(cyc, got);
        checks++;
        if (!got || cyc != 16 || z_a !== 4'd6) begin
            errors++;
            $display("FAIL abort_after: got=%0d cycles=%0d z=%0d expected 6", got, cyc, z_a);
        end
        // abort coinciding with the terminal edge
        go_a(3, 1, 0);
        repeat (15) @(negedge clk);
        abort_a = 1;
        @(negedge clk);
        abort_a = 0;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || z_a !== 4'd6) begin
            errors++;
            $display("FAIL abort_terminal: busy=%b done=%b z=%0d expected 0 0 6", busy_a, done_a, z_a);
        end
        // start with abort in IDLE: start wins
        @(negedge clk);
        x_a = {2'd1, 2'd1};
        mode_a = 0;
        start_a = 1;
        abort_a = 1;
        @(negedge clk);
        start_a = 0;
        abort_a = 0;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b expected 1", busy_a);
        end
        wait_a(cyc, got);
        checks++;
        if (!got || z_a !== 4'd1) begin
            errors++;
            $display("FAIL start_abort_run: got=%0d z=%0d expected 1", got, z_a);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        bit got;
        go_a(3, 3, 0);
        wait_a(cyc, got);
        go_a(2, 2, 0);
        repeat (4) @(negedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || z_a !== 4'd0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b done=%b z=%0d expected 0 0 0", busy_a, done_a, z_a);
        end
        @(negedge clk);
        rst = 0;
        go_a(1, 3, 0);
        wait_a(cyc, got);
        checks++;
        if (!got || cyc != 16 || z_a !== 4'd3) begin
            errors++;
            $display("FAIL reset_rerun: got=%0d cycles=%0d z=%0d expected 3", got, cyc, z_a);
        end
    endtask

    initial begin
        test_reset();
        test_product();
        test_or();
        test_wide();
        test_handshake();
        test_abort();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
